// File: rtl/prim_skid_buf.sv
// Two-entry valid/ready skid buffer: registers forward and backward paths, 1 beat/cycle, latency 1.
// Optional synchronous flush port is enabled by defining PRIM_SKID_BUF_FLUSH_EN.
module prim_skid_buf #(
    parameter int unsigned           Width     = 32,
    parameter logic [Width-1:0]      ResetData = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [Width-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [Width-1:0] out_data_o,
    input  logic             out_ready_i,
    output logic [1:0]       count_o
`ifdef PRIM_SKID_BUF_FLUSH_EN
    ,
    input  logic             flush_i
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [Width-1:0] main_q, main_d;
    logic [Width-1:0] skid_q, skid_d;
    logic             flush;
    logic             in_xfer;
    logic             out_xfer;

`ifdef PRIM_SKID_BUF_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // Handshake valid/ready: a beat moves on a port only in a cycle where both valid and ready are high.
    assign in_xfer  = in_valid_i && (state_q != FULL);
    assign out_xfer = (state_q != EMPTY) && out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_d  = in_data_i;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = in_data_i;
                end else if (in_xfer) begin
                    skid_d  = in_data_i;
                    state_d = FULL;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops occupancy only; data registers keep their contents.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            main_q  <= ResetData;
            skid_q  <= ResetData;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_data_o  = main_q;
    assign out_valid_o = (state_q != EMPTY);
    assign in_ready_o  = (state_q != FULL);
    assign count_o     = state_q;

endmodule

// File: tb/tb_prim_skid_buf.sv
// Directed vector table plus random scoreboard stress for prim_skid_buf.
module tb_prim_skid_buf;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic [1:0]   count;
    logic         flush;

    int tests_run;
    int tests_failed;

    logic [W-1:0] exp_q[$];

    prim_skid_buf #(.Width(W), .ResetData('0)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready),
        .count_o     (count)
`ifdef PRIM_SKID_BUF_FLUSH_EN
        ,
        .flush_i     (flush)
`endif
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         rst;
        logic         flush;
        logic         in_valid;
        logic [W-1:0] in_data;
        logic         out_ready;
        logic         exp_out_valid;
        logic         exp_in_ready;
        logic [1:0]   exp_count;
        logic [W-1:0] exp_out_data;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input logic [W-1:0] d,
                                input logic ordy, input logic eov, input logic eir,
                                input logic [1:0] ec, input logic [W-1:0] eod);
        vec_t t;
        t.rst = r; t.flush = 1'b0; t.in_valid = v; t.in_data = d; t.out_ready = ordy;
        t.exp_out_valid = eov; t.exp_in_ready = eir; t.exp_count = ec; t.exp_out_data = eod;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    // Driver: apply one vector before the edge, check registered outputs just after it.
    task automatic apply(input vec_t t, input int idx);
        @(negedge clk);
        rst = t.rst; flush = t.flush; in_valid = t.in_valid;
        in_data = t.in_data; out_ready = t.out_ready;
        @(posedge clk);
        #1;
        check("out_valid", idx, W'(out_valid), W'(t.exp_out_valid));
        check("in_ready",  idx, W'(in_ready),  W'(t.exp_in_ready));
        check("count",     idx, W'(count),     W'(t.exp_count));
        check("out_data",  idx, out_data,      t.exp_out_data);
    endtask

    vec_t vecs[23];

    initial begin
        int pushed;
        int cycles;
        logic prev_stall;
        logic [W-1:0] prev_data;
        vec_t f;

        tests_run = 0; tests_failed = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // reset with a beat presented: dropped
        vecs[0]  = mk(1, 1, 32'hDEAD_BEEF, 0, 0, 1, 0, 32'h0);
        vecs[1]  = mk(1, 1, 32'hDEAD_BEEF, 0, 0, 1, 0, 32'h0);
        vecs[2]  = mk(0, 0, 32'h0,         1, 0, 1, 0, 32'h0);
        // streaming 1..8
        for (int i = 0; i < 8; i++)
            vecs[3+i] = mk(0, 1, W'(i+1), 1, 1, 1, 1, W'(i+1));
        vecs[11] = mk(0, 0, 32'h0, 1, 0, 1, 0, 32'h8);
        // backpressure / skid
        vecs[12] = mk(0, 1, 32'hA, 0, 1, 1, 1, 32'hA);
        vecs[13] = mk(0, 1, 32'hB, 0, 1, 0, 2, 32'hA);
        vecs[14] = mk(0, 1, 32'hC, 0, 1, 0, 2, 32'hA);
        vecs[15] = mk(0, 1, 32'hC, 1, 1, 1, 1, 32'hB);
        vecs[16] = mk(0, 1, 32'hC, 1, 1, 1, 1, 32'hC);
        vecs[17] = mk(0, 0, 32'h0, 1, 0, 1, 0, 32'hC);
        // reset mid-operation from FULL
        vecs[18] = mk(0, 1, 32'h11, 0, 1, 1, 1, 32'h11);
        vecs[19] = mk(0, 1, 32'h22, 0, 1, 0, 2, 32'h11);
        vecs[20] = mk(1, 0, 32'h0,  0, 0, 1, 0, 32'h0);
        vecs[21] = mk(0, 1, 32'h33, 0, 1, 1, 1, 32'h33);
        vecs[22] = mk(0, 0, 32'h0,  1, 0, 1, 0, 32'h33);

        for (int i = 0; i < 23; i++) apply(vecs[i], i);

`ifdef PRIM_SKID_BUF_FLUSH_EN
        apply(mk(0, 1, 32'h44, 0, 1, 1, 1, 32'h44), 100);
        apply(mk(0, 1, 32'h55, 0, 1, 0, 2, 32'h44), 101);
        f = mk(0, 1, 32'h66, 1, 0, 1, 0, 32'h44);
        f.flush = 1'b1;
        apply(f, 102);
        apply(mk(0, 1, 32'h77, 1, 1, 1, 1, 32'h77), 103);
        apply(mk(0, 0, 32'h0,  1, 0, 1, 0, 32'h77), 104);
`else
        f = '0;
`endif

        // Random stress with scoreboard; buffer is EMPTY here.
        pushed = 0; cycles = 0; prev_stall = 1'b0; prev_data = '0;
        while ((pushed < 10000 || exp_q.size() != 0) && cycles < 60000) begin
            @(negedge clk);
            rst = 1'b0; flush = 1'b0;
            in_valid  = (pushed < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data   = W'($urandom);
            out_ready = (pushed < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            check("rnd_count", cycles, W'(count), W'(exp_q.size()));
            if (prev_stall) begin
                check("stall_valid", cycles, W'(out_valid), W'(1));
                check("stall_data",  cycles, out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_extra_beat", cycles, W'(1), W'(0));
                end else begin
                    check("rnd_data", cycles, out_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                pushed++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            cycles++;
        end
        check("rnd_timeout", cycles, W'(cycles < 60000), W'(1));
        check("rnd_pushed",  cycles, W'(pushed), W'(10000));

        // Final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/prim_skid_buf.md
Name: prim_skid_buf

Overview:
- Two-entry valid/ready skid buffer placed directly upstream of the primitive buffer cell (prim_generic_buf) on timing-critical datapaths.
- Registers the payload and breaks both the forward path (valid/data) and the backward path (ready), so the downstream buffer cell drives a fully registered net.
- Sustains full throughput (1 beat/cycle) with 1-cycle latency. It is meant for long routes between ibex pipeline stages and the bus interfaces.

Parameters:
- Width, 32, payload width in bits (>=1).
- ResetData, '0, reset value of both data registers, Width bits.

Ports:
- clk_i  input  1  clock, all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- in_valid_i  input  1  upstream beat valid.
- in_data_i  input  Width  upstream payload.
- in_ready_o  output  1  buffer can accept a beat this cycle; decoded from registered state only.
- out_valid_o  output  1  output beat valid; registered.
- out_data_o  output  Width  output payload; registered, feeds prim_generic_buf in_i.
- out_ready_i  input  1  downstream accepts the beat.
- count_o  output  2  occupancy, 0..2; registered.

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (rst_i).
- Handshakes:
  - Upstream transfer when in_valid_i && in_ready_o.
  - Downstream transfer when out_valid_o && out_ready_i.
- State register has three values: EMPTY (count 0), ONE (main valid), FULL (main + skid valid).
- Output decode:
  - out_data_o = main register.
  - out_valid_o = (state != EMPTY).
  - in_ready_o = (state != FULL).
  - count_o = state encoding 0/1/2.
- in_ready_o has no combinational path from out_ready_i, in_valid_i or in_data_i.
- Reset values, applied in the cycle rst_i is sampled high:
  - state = EMPTY, so out_valid_o = 0, in_ready_o = 1, count_o = 0.
  - main and skid registers = ResetData, so out_data_o = ResetData.
  - Reset wins over every other event. A beat presented while rst_i = 1 is dropped.
- EMPTY:
  - Upstream transfer: main <= in_data_i, go to ONE. The beat appears on out_data_o the next cycle (latency 1).
  - No transfer: stay in EMPTY.
- ONE:
  - Upstream and downstream transfer together: main <= in_data_i, stay in ONE (full throughput).
  - Upstream transfer only: skid <= in_data_i, go to FULL; main is unchanged.
  - Downstream transfer only: go to EMPTY.
  - Neither: hold.
- FULL:
  - in_ready_o = 0. No upstream transfer is possible regardless of in_valid_i.
  - Downstream transfer: main <= skid, go to ONE.
  - Otherwise: hold.
- Ordering: beats leave in arrival order, with no loss and no duplication.
- Stability: while out_valid_o = 1 and out_ready_i = 0, out_data_o and out_valid_o hold stable.
- Data registers:
  - Written only on the transitions listed above.
  - When leaving ONE for EMPTY, main keeps its stale value. out_data_o is don't-care while out_valid_o = 0, but it must not toggle.
- Upstream protocol violations (e.g. data changing while valid is high and ready is low) need no special handling. The block samples only on transfer.

Optional Feature:
- Macro: PRIM_SKID_BUF_FLUSH_EN.
- When defined:
  - Adds port flush_i (input, 1): synchronous flush.
  - When flush_i = 1 and rst_i = 0: state <= EMPTY next cycle.
  - Any upstream beat presented in that cycle is discarded, even though in_ready_o may be 1.
  - Data registers retain their values.
  - Priority order: rst_i > flush_i > normal transitions.
  - in_ready_o is still not combinationally dependent on flush_i.
- When undefined:
  - The port does not exist.
  - Behaviour is identical to flush_i tied to 0.

Test Plan:
- Reset: hold rst_i for 2 cycles with in_valid_i = 1 and in_data_i = 32'hDEAD_BEEF -> out_valid_o = 0, in_ready_o = 1, count_o = 0, out_data_o = 0; no beat emerges after reset releases.
- Streaming: out_ready_i = 1, push 0x1..0x8 on consecutive cycles -> out_data_o shows 0x1..0x8 on consecutive cycles, each 1 cycle after its input; count_o stays 1; in_ready_o never drops.
- Backpressure/skid: push 0xA, 0xB, 0xC with out_ready_i = 0 -> 0xA and 0xB accepted, count_o = 2, in_ready_o = 0, 0xC held upstream. Release out_ready_i -> output order 0xA, 0xB, 0xC, with count_o going 2 -> 1 -> 1 -> 0.
- Random stress: random in_valid_i/out_ready_i at 50%, 10k beats -> scoreboard shows in-order, lossless, no duplicates; out_data_o stable under stall.
- Reset mid-operation: FULL holding 0x11 and 0x22, assert rst_i for 1 cycle -> EMPTY next cycle, out_data_o = ResetData; subsequent beat 0x33 is the first output.
- Flush (PRIM_SKID_BUF_FLUSH_EN): FULL holding 0x44 and 0x55, flush_i = 1 with in_valid_i = 1 and data 0x66 -> next cycle count_o = 0; 0x44, 0x55 and 0x66 never appear; a following beat 0x77 emerges normally.
